// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with PC mirror, LR capture and busy scoreboard (optional RF_BYPASS_EN)
module regfile_sb #(
    parameter int             W         = 32,
    parameter int             AW        = 3,
    parameter int             PC_IDX    = 7,
    parameter int             LR_IDX    = 6,
    parameter logic [W-1:0]   LR_RESET  = 'h1000,
    parameter logic [W-1:0]   PC_OFFSET = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [W-1:0]  o_rd1,
    output logic [W-1:0]  o_rd2,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [W-1:0]  i_wd,
    input  logic [W-1:0]  i_pc_in,
    input  logic          i_lr_we,
    input  logic          i_rsv_en,
    input  logic [AW-1:0] i_rsv_addr,
    output logic          o_busy1,
    output logic          o_busy2,
    output logic          o_hazard
);

    localparam int NREG = 2 ** AW;

    logic [W-1:0]    r_regs      [NREG];
    logic [W-1:0]    w_regs_next [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [NREG-1:0] w_wr_dec;
    logic [NREG-1:0] w_rsv_dec;
    logic [W-1:0]    w_lr_capture;
    logic            w_byp1;
    logic            w_byp2;

    // Link value wraps modulo 2**W; no flag is produced.
    assign w_lr_capture = i_pc_in - PC_OFFSET;

    // One-hot decode of the explicit write and of the reservation; the PC
    // mirror can never be reserved, so its busy bit stays clear for good.
    always_comb begin
        w_wr_dec  = '0;
        w_rsv_dec = '0;
        if (i_we) begin
            w_wr_dec[i_wa] = 1'b1;
        end
        if (i_rsv_en && (i_rsv_addr != AW'(PC_IDX))) begin
            w_rsv_dec[i_rsv_addr] = 1'b1;
        end
    end

    // Next register contents: explicit write beats the PC mirror update and
    // the LR capture; plain registers only change on an explicit write.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_regs_next[i] = r_regs[i];
            if (w_wr_dec[i]) begin
                w_regs_next[i] = i_wd;
            end else if (i == PC_IDX) begin
                w_regs_next[i] = i_pc_in;
            end else if ((i == LR_IDX) && i_lr_we) begin
                w_regs_next[i] = w_lr_capture;
            end
        end
    end

    // Register storage; LR comes out of reset at its boot value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == LR_IDX) ? LR_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= w_regs_next[i];
            end
        end
    end

    // Writeback clears a busy bit, a reservation sets one; set wins on a tie.
    assign w_busy_next = (r_busy & ~w_wr_dec) | w_rsv_dec;

    // Scoreboard state; reset drops every outstanding reservation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

`ifdef RF_BYPASS_EN
    // Forward the writeback value to a reader of the same register this cycle.
    assign w_byp1 = i_we && (i_wa == i_ra1);
    assign w_byp2 = i_we && (i_wa == i_ra2);
`else
    // No forwarding: reads see stored state only.
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Combinational read ports and hazard flags.
    always_comb begin
        o_rd1    = w_byp1 ? i_wd : r_regs[i_ra1];
        o_rd2    = w_byp2 ? i_wd : r_regs[i_ra2];
        o_busy1  = r_busy[i_ra1] && !w_byp1;
        o_busy2  = r_busy[i_ra2] && !w_byp2;
        o_hazard = o_busy1 || o_busy2;
    end

endmodule
